// File: rtl/logic_unit_serial_if.sv
// Request/response bundle for logic_unit_serial; the parity signal exists only
// when LOGIC_UNIT_PARITY_EN is defined.
interface logic_unit_serial_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             zero;
`ifdef LOGIC_UNIT_PARITY_EN
  logic             parity;

  modport master (output start, op, a, b, input result, busy, done, zero, parity);
  modport slave  (input start, op, a, b, output result, busy, done, zero, parity);
`else
  modport master (output start, op, a, b, input result, busy, done, zero);
  modport slave  (input start, op, a, b, output result, busy, done, zero);
`endif
endinterface

// File: rtl/logic_unit_serial.sv
// Multi-cycle AND/OR/XOR/NOR unit processing SLICE bits per clock, LSB slice first.
// Optional parity output is enabled by defining LOGIC_UNIT_PARITY_EN.
module logic_unit_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic            clk,
  input  logic            reset,
  logic_unit_serial_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             w_accept;
  logic             w_last;
  logic [SLICE-1:0] w_slice_a;
  logic [SLICE-1:0] w_slice_b;
  logic [SLICE-1:0] w_slice_res;
  logic [WIDTH-1:0] w_next_result;
`ifdef LOGIC_UNIT_PARITY_EN
  logic             r_parity;
`endif

  assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(NSLICE - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: default assignment first keeps combinational blocks free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  w_next_state = bus.start ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (r_state == S_RUN);
    bus.done   = (r_state == S_DONE);
    bus.result = r_result;
    bus.zero   = r_zero;
`ifdef LOGIC_UNIT_PARITY_EN
    bus.parity = r_parity;
`endif
  end

  // One slice of the selected function, merged into the current partial word
  always_comb begin
    w_slice_a = r_a[r_cnt*SLICE +: SLICE];
    w_slice_b = r_b[r_cnt*SLICE +: SLICE];
    case (r_op)
      2'b00:   w_slice_res = w_slice_a & w_slice_b;
      2'b01:   w_slice_res = w_slice_a | w_slice_b;
      2'b10:   w_slice_res = w_slice_a ^ w_slice_b;
      default: w_slice_res = ~(w_slice_a | w_slice_b);
    endcase
    w_next_result = r_result;
    w_next_result[r_cnt*SLICE +: SLICE] = w_slice_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_op     <= bus.op;
      r_result <= '0;
      r_zero   <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (r_state == S_RUN) begin
      r_cnt    <= r_cnt + 1'b1;
      r_result <= w_next_result;
      // Flags look at the full word including the slice written on this edge
      if (w_last) begin
        r_zero   <= ~|w_next_result;
`ifdef LOGIC_UNIT_PARITY_EN
        r_parity <= ^w_next_result;
`endif
      end
    end
  end
endmodule

// File: tb/tb_logic_unit_serial.sv
// Self-checking bench: a transaction-level model predicts busy/done/result/zero every
// cycle for the 32/8 instance; a 16/16 instance checks single-pass operation.
module tb_logic_unit_serial;
  localparam int W  = 32;
  localparam int S  = 8;
  localparam int NS = W / S;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  logic_unit_serial_if #(.WIDTH(W))  bus   ();
  logic_unit_serial_if #(.WIDTH(16)) bus16 ();

  logic_unit_serial #(.WIDTH(W), .SLICE(S)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  logic_unit_serial #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic logic [W-1:0] low_mask(input int k);
    logic [63:0] m;
    if (k * S >= W) return '1;
    m = (64'd1 << (k * S)) - 64'd1;
    return m[W-1:0];
  endfunction

  // m_phase: 0 idle, 1..NS cycles into the run, NS+1 the done cycle
  int           m_phase = 0;
  logic [W-1:0] m_final = '0;
  logic [W-1:0] m_result = '0;
  logic         m_zero = 1'b0;
  logic         m_par = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_result = '0; m_zero = 1'b0; m_par = 1'b0;
    end else if (bus.start && (m_phase == 0 || m_phase == NS + 1)) begin
      m_phase  = 1;
      m_final  = ref_op(bus.op, bus.a, bus.b);
      m_result = '0; m_zero = 1'b0; m_par = 1'b0;
    end else if (m_phase >= 1 && m_phase <= NS) begin
      m_phase++;
      m_result = m_final & low_mask(m_phase - 1);
      if (m_phase == NS + 1) begin
        m_zero = (m_final == '0);
        m_par  = ^m_final;
      end
    end else if (m_phase == NS + 1) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", bus.busy, (m_phase >= 1 && m_phase <= NS));
      check("done", bus.done, (m_phase == NS + 1));
      check("result", bus.result, m_result);
      if (!(m_phase >= 1 && m_phase <= NS)) begin
        check("zero", bus.zero, m_zero);
`ifdef LOGIC_UNIT_PARITY_EN
        check("parity", bus.parity, m_par);
`endif
      end
      if (bus.done) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic s, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = s; bus.op = op; bus.a = a; bus.b = b;
  endtask

  task automatic wait_done(output int n, input bit drop_start);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop_start) bus.start = 1'b0;
    end while (!bus.done && n < 20);
    check("done_seen", bus.done, 1'b1);
  endtask

  logic [W-1:0] tab_exp [4];
  int n;
  int d0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tab_exp[0] = 32'h00001000;
    tab_exp[1] = 32'h11111111;
    tab_exp[2] = 32'h11110111;
    tab_exp[3] = 32'hEEEEEEEE;

    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus16.start = 0; bus16.op = 0; bus16.a = 0; bus16.b = 0;

    // Reset for two cycles, then idle
    @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_result", bus.result, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);
    check("idle_zero", bus.zero, 0);

    // Single XOR, latency and flags
    d0 = done_cnt;
    drive(1, OP_XOR, 32'hFFFFFFFF, 32'h00000000);
    wait_done(n, 1);
    check("latency", n, NS + 1);
    check("xor_ff_result", bus.result, 32'hFFFFFFFF);
    check("xor_ff_zero", bus.zero, 0);
`ifdef LOGIC_UNIT_PARITY_EN
    check("xor_ff_parity", bus.parity, 0);
`endif
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("one_done_pulse", done_cnt - d0, 1);

    // Back-to-back with start held high
    drive(1, OP_XOR, 32'h12311111, 32'h00100000);
    @(negedge clk);
    bus.a = 32'h10000100; bus.b = 32'h11000010;
    n = 1;
    while (!bus.done && n < 20) begin @(negedge clk); n++; end
    check("b2b_first", bus.result, 32'h12211111);
    wait_done(n, 0);
    bus.start = 0;
    check("b2b_gap", n, NS + 1);
    check("b2b_second", bus.result, 32'h01000110);

    // Each operation on the same operands
    for (int op = 0; op < 4; op++) begin
      drive(1, 2'(op), 32'h11111000, 32'h00001111);
      wait_done(n, 1);
      check("op_table", bus.result, tab_exp[op]);
    end
    drive(1, OP_XOR, 32'hA5A5A5A5, 32'hA5A5A5A5);
    wait_done(n, 1);
    check("zero_result", bus.result, 0);
    check("zero_flag", bus.zero, 1);

    // Operand changes and start pulses during RUN are ignored
    drive(1, OP_OR, 32'h0F0F0000, 32'h0000F0F0);
    @(negedge clk);
    bus.start = 0; bus.a = '1; bus.b = '1; bus.op = OP_AND;
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    wait_done(n, 1);
    check("interfere_result", bus.result, 32'h0F0FF0F0);

    // Reset in the second RUN cycle abandons the operation
    drive(1, OP_XOR, 32'hFFFF0000, 32'h0000FFFF);
    @(negedge clk);
    bus.start = 0;
    @(negedge clk);
    rst = 1;
    d0 = done_cnt;
    @(negedge clk);
    rst = 0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.zero, 0);
    repeat (6) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);
    drive(1, OP_AND, 32'hF0F0F0F0, 32'hFF00FF00);
    wait_done(n, 1);
    check("after_rst_latency", n, NS + 1);
    check("after_rst_result", bus.result, 32'hF000F000);

    // Single-pass instance
    @(negedge clk);
    bus16.start = 1; bus16.op = OP_XOR; bus16.a = 16'hF0F0; bus16.b = 16'h0FF0;
    @(negedge clk);
    bus16.start = 0;
    check("w16_busy", bus16.busy, 1);
    check("w16_done_early", bus16.done, 0);
    @(negedge clk);
    check("w16_done", bus16.done, 1);
    check("w16_result", bus16.result, 16'hFF00);
    check("w16_zero", bus16.zero, 0);
`ifdef LOGIC_UNIT_PARITY_EN
    check("w16_parity", bus16.parity, 0);
`endif
    @(negedge clk);
    check("w16_done_drop", bus16.done, 0);
    check("w16_hold", bus16.result, 16'hFF00);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.op    = 2'($urandom_range(0, 3));
      bus.a     = $urandom;
      bus.b     = ($urandom_range(0, 5) == 0) ? bus.a : $urandom;
      if ($urandom_range(0, 7) == 0) bus.b = ~bus.a;
      rst       = ($urandom_range(0, 60) == 0);
    end
    @(negedge clk);
    bus.start = 0; rst = 0;
    repeat (NS + 3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
